// File: rtl/cfi_pkg.sv
// Shared types and helpers for the commit-stage CFI shadow-stack monitor.
// Holds a reduced Ariane scoreboard entry and the monitor's own enums.
package cfi_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned NR_COMMIT_PORTS = 2;

    localparam logic [4:0] X1 = 5'd1;
    localparam logic [4:0] X5 = 5'd5;

    // Subset of the Ariane functional-unit opcodes the monitor cares about
    typedef enum logic [3:0] {
        ADD,
        ADDW,
        SUB,
        LD,
        SD,
        BEQ,
        JAL,
        JALR
    } fu_op;

    typedef struct packed {
        logic valid;
    } exception_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        fu_op            op;
        logic [4:0]      rs1;
        logic [4:0]      rd;
        logic            is_compressed;
        exception_t      ex;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        RET_MISMATCH = 2'd1,
        UNDERFLOW    = 2'd2
    } cfi_cause_e;

    typedef enum logic {
        IDLE,
        PENDING
    } cfi_state_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == X1) || (r == X5);
    endfunction

endpackage

// File: rtl/cfi_ras_buffer.sv
// Circular return-address stack with DEPTH entries.
// Each port slot is applied in port order: flush, then pop, then push.
// A push into a full stack overwrites the oldest entry and raises drop for
// that slot; a pop from an empty stack is ignored and reported via pop_valid.
module cfi_ras_buffer
    import cfi_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned W        = VLEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NR_PORTS-1:0]             flush,
    input  logic [NR_PORTS-1:0]             pop,
    input  logic [NR_PORTS-1:0]             push,
    input  logic [NR_PORTS-1:0][W-1:0]      push_data,
    output logic [NR_PORTS-1:0]             pop_valid,
    output logic [NR_PORTS-1:0][W-1:0]      pop_data,
    output logic [NR_PORTS-1:0]             drop,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Chain the per-port operations so a later slot sees earlier slots' effect
    always_comb begin
        mem_d     = mem_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        pop_valid = '0;
        pop_data  = '0;
        drop      = '0;
        for (int p = 0; p < int'(NR_PORTS); p++) begin
            if (flush[p]) begin
                cnt_d = '0;
            end
            if (pop[p] && (cnt_d != '0)) begin
                ptr_d        = ptr_d - PTR_W'(1);
                pop_valid[p] = 1'b1;
                pop_data[p]  = mem_d[ptr_d];
                cnt_d        = cnt_d - CNT_W'(1);
            end
            if (push[p]) begin
                mem_d[ptr_d] = push_data[p];
                ptr_d        = ptr_d + PTR_W'(1);
                if (cnt_d == CNT_W'(DEPTH)) begin
                    drop[p] = 1'b1;
                end else begin
                    cnt_d = cnt_d + CNT_W'(1);
                end
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents beyond the occupancy are don't-care
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/cfi_shadow_stack_monitor.sv
// Commit-stage CFI monitor: shadow return-address stack over all commit ports.
// Optional feature macro CFI_MARKER_EN: ADDW x0,x1 acts as a software marker
// that empties the stack, zeroes the lost count and cancels a pending check.
//
//   state   | meaning
//   IDLE    | no return target awaiting comparison
//   PENDING | a return popped; next acked instruction is compared to expected
module cfi_shadow_stack_monitor
    import cfi_pkg::*;
#(
    parameter int unsigned NR_PORTS = NR_COMMIT_PORTS,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LOST_W   = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  scoreboard_entry_t [NR_PORTS-1:0]    commit_instr_i,
    input  logic [NR_PORTS-1:0]                 commit_ack_i,
    input  logic                                clear_alarm_i,
    output logic                                violation_o,
    output logic                                alarm_o,
    output logic [1:0]                          cause_o,
    output logic [VLEN-1:0]                     violation_pc_o,
    output logic [$clog2(DEPTH):0]              depth_o,
    output logic                                overflow_o
);

    localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};

    logic [NR_PORTS-1:0]            marker, push, pop;
    logic [NR_PORTS-1:0][VLEN-1:0]  push_data;
    logic [NR_PORTS-1:0]            pop_valid, drop;
    logic [NR_PORTS-1:0][VLEN-1:0]  pop_data;

    cfi_state_e         state_q, state_d;
    logic [VLEN-1:0]    expected_q, expected_d;
    logic [LOST_W-1:0]  lost_q, lost_d;
    logic               found;
    cfi_cause_e         found_cause;
    logic [VLEN-1:0]    found_pc;

    logic               violation_q, alarm_q;
    cfi_cause_e         cause_q;
    logic [VLEN-1:0]    violation_pc_q;

    function automatic logic is_call(input scoreboard_entry_t e);
        return ((e.op == JAL) || (e.op == JALR)) && is_link(e.rd);
    endfunction

    // A JALR with rd == rs1 == link is a call only; differing links pop then push
    function automatic logic is_ret(input scoreboard_entry_t e);
        return (e.op == JALR) && is_link(e.rs1) &&
               (!is_link(e.rd) || (e.rd != e.rs1));
    endfunction

`ifdef CFI_MARKER_EN
    function automatic logic is_marker(input scoreboard_entry_t e);
        return (e.op == ADDW) && (e.rd == 5'd0) && (e.rs1 == X1);
    endfunction
`endif

    // Marker detection per port (constant zero when the feature is compiled out)
    always_comb begin
        marker = '0;
`ifdef CFI_MARKER_EN
        for (int p = 0; p < int'(NR_PORTS); p++) begin
            marker[p] = commit_ack_i[p] && !commit_instr_i[p].ex.valid &&
                        is_marker(commit_instr_i[p]);
        end
`endif
    end

    // Stack requests depend only on the instruction, never on stack state
    always_comb begin
        push      = '0;
        pop       = '0;
        push_data = '0;
        for (int p = 0; p < int'(NR_PORTS); p++) begin
            if (commit_ack_i[p] && !commit_instr_i[p].ex.valid && !marker[p]) begin
                push[p] = is_call(commit_instr_i[p]);
                pop[p]  = is_ret(commit_instr_i[p]);
            end
            push_data[p] = commit_instr_i[p].pc +
                           (commit_instr_i[p].is_compressed ? VLEN'(2) : VLEN'(4));
        end
    end

    cfi_ras_buffer #(
        .NR_PORTS (NR_PORTS),
        .DEPTH    (DEPTH),
        .W        (VLEN)
    ) i_ras (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (marker),
        .pop       (pop),
        .push      (push),
        .push_data (push_data),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .drop      (drop),
        .count     (depth_o)
    );

    // Next-state chain across ports: pending check, pop outcome, lost count
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        lost_d      = lost_q;
        found       = 1'b0;
        found_cause = NONE;
        found_pc    = '0;
        for (int p = 0; p < int'(NR_PORTS); p++) begin
            if (commit_ack_i[p]) begin
                if (commit_instr_i[p].ex.valid) begin
                    state_d = IDLE;
                end else if (marker[p]) begin
                    state_d = IDLE;
                    lost_d  = '0;
                end else begin
                    if (state_d == PENDING) begin
                        if ((commit_instr_i[p].pc != expected_d) && !found) begin
                            found       = 1'b1;
                            found_cause = RET_MISMATCH;
                            found_pc    = commit_instr_i[p].pc;
                        end
                        state_d = IDLE;
                    end
                    if (pop[p]) begin
                        if (pop_valid[p]) begin
                            state_d    = PENDING;
                            expected_d = pop_data[p];
                        end else if (lost_d != '0) begin
                            lost_d = lost_d - LOST_W'(1);
                        end else if (!found) begin
                            found       = 1'b1;
                            found_cause = UNDERFLOW;
                            found_pc    = commit_instr_i[p].pc;
                        end
                    end
                    if (drop[p] && (lost_d != LOST_MAX)) begin
                        lost_d = lost_d + LOST_W'(1);
                    end
                end
            end
        end
    end

    // FSM, expected target and lost-count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            expected_q <= '0;
            lost_q     <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            lost_q     <= lost_d;
        end
    end

    // Violation pulse, sticky alarm and first-cause capture; violation beats clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            violation_q    <= 1'b0;
            violation_pc_q <= '0;
            alarm_q        <= 1'b0;
            cause_q        <= NONE;
        end else begin
            violation_q <= found;
            if (found) begin
                violation_pc_q <= found_pc;
                alarm_q        <= 1'b1;
                if (!alarm_q) begin
                    cause_q <= found_cause;
                end
            end else if (clear_alarm_i) begin
                alarm_q <= 1'b0;
                cause_q <= NONE;
            end
        end
    end

    assign violation_o    = violation_q;
    assign violation_pc_o = violation_pc_q;
    assign alarm_o        = alarm_q;
    assign cause_o        = cause_q;
    assign overflow_o     = (lost_q != '0);

endmodule

// File: tb/tb_cfi_shadow_stack_monitor.sv
// Bench for cfi_shadow_stack_monitor: directed scenarios followed by random
// commit traffic, all checked against a queue-based reference model.
// Honours CFI_MARKER_EN the same way as the design.
module tb_cfi_shadow_stack_monitor;
    import cfi_pkg::*;

    localparam int NRP    = 2;
    localparam int DEPTH  = 8;
    localparam int LOST_W = 8;

    logic                           clk = 1'b0;
    logic                           rst;
    scoreboard_entry_t [NRP-1:0]    ci;
    logic [NRP-1:0]                 ack;
    logic                           clr;
    logic                           violation_o, alarm_o, overflow_o;
    logic [1:0]                     cause_o;
    logic [VLEN-1:0]                violation_pc_o;
    logic [$clog2(DEPTH):0]         depth_o;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [63:0] m_stack[$];
    int          m_lost;
    bit          m_pend;
    logic [63:0] m_exp;
    bit          m_viol, m_alarm;
    int          m_cause;
    logic [63:0] m_vpc;

    cfi_shadow_stack_monitor #(
        .NR_PORTS (NRP),
        .DEPTH    (DEPTH),
        .LOST_W   (LOST_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .commit_instr_i (ci),
        .commit_ack_i   (ack),
        .clear_alarm_i  (clr),
        .violation_o    (violation_o),
        .alarm_o        (alarm_o),
        .cause_o        (cause_o),
        .violation_pc_o (violation_pc_o),
        .depth_o        (depth_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NRP; p++) begin
            ci[p]    = '0;
            ci[p].op = ADD;
        end
        ack = '0;
        clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic put(input int p, input logic [63:0] pc, input fu_op op,
                       input logic [4:0] rs1, input logic [4:0] rd, input bit comp);
        ci[p].pc            = pc;
        ci[p].op            = op;
        ci[p].rs1           = rs1;
        ci[p].rd            = rd;
        ci[p].is_compressed = comp;
        ci[p].ex.valid      = 1'b0;
        ack[p]              = 1'b1;
    endtask

    task automatic do_call(input int p, input logic [63:0] pc, input bit comp);
        put(p, pc, JAL, 5'd0, 5'd1, comp);
    endtask

    task automatic do_ret(input int p, input logic [63:0] pc);
        put(p, pc, JALR, 5'd1, 5'd0, 1'b0);
    endtask

    task automatic do_plain(input int p, input logic [63:0] pc);
        put(p, pc, ADD, 5'd2, 5'd3, 1'b0);
    endtask

    // One clock of the architectural rules, applied to the current inputs
    task automatic model_cycle();
        bit found;
        int fc;
        logic [63:0] fpc;
        scoreboard_entry_t e;
        bit r, c;
        if (rst) begin
            m_stack.delete();
            m_lost = 0; m_pend = 0; m_exp = '0;
            m_viol = 0; m_alarm = 0; m_cause = 0; m_vpc = '0;
            return;
        end
        found = 0; fc = 0; fpc = '0;
        for (int p = 0; p < NRP; p++) begin
            e = ci[p];
            if (!ack[p]) continue;
            if (e.ex.valid) begin
                m_pend = 0;
                continue;
            end
`ifdef CFI_MARKER_EN
            if (e.op == ADDW && e.rd == 5'd0 && e.rs1 == 5'd1) begin
                m_stack.delete();
                m_lost = 0;
                m_pend = 0;
                continue;
            end
`endif
            if (m_pend) begin
                m_pend = 0;
                if (e.pc !== m_exp && !found) begin
                    found = 1; fc = 1; fpc = e.pc;
                end
            end
            r = (e.op == JALR) && lnk(e.rs1) && !(lnk(e.rd) && e.rd == e.rs1);
            c = (e.op == JAL || e.op == JALR) && lnk(e.rd);
            if (r) begin
                if (m_stack.size() > 0) begin
                    m_exp  = m_stack.pop_back();
                    m_pend = 1;
                end else if (m_lost > 0) begin
                    m_lost--;
                end else if (!found) begin
                    found = 1; fc = 2; fpc = e.pc;
                end
            end
            if (c) begin
                m_stack.push_back(e.pc + (e.is_compressed ? 64'd2 : 64'd4));
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    if (m_lost < 2**LOST_W - 1) m_lost++;
                end
            end
        end
        m_viol = found;
        if (found) begin
            m_vpc = fpc;
            if (!m_alarm) m_cause = fc;
            m_alarm = 1;
        end else if (clr) begin
            m_alarm = 0;
            m_cause = 0;
        end
    endtask

    task automatic check_outputs();
        chk("violation",    64'(violation_o),    64'(m_viol));
        chk("alarm",        64'(alarm_o),        64'(m_alarm));
        chk("cause",        64'(cause_o),        64'(m_cause));
        chk("violation_pc", violation_pc_o,      m_vpc);
        chk("depth",        64'(depth_o),        64'(m_stack.size()));
        chk("overflow",     64'(overflow_o),     64'(m_lost > 0));
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        check_outputs();
        clear_inputs();
    endtask

    task automatic rand_port(input int p);
        int k;
        logic [63:0] pc;
        logic [4:0] a, b;
        k  = $urandom_range(0, 19);
        pc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 2;
        if (p == 0 && m_pend && $urandom_range(0, 3) != 0) pc = m_exp;
        if (p == 1 && ack[0] && ci[0].op == JALR && lnk(ci[0].rs1) &&
            m_stack.size() > 0 && $urandom_range(0, 3) != 0) pc = m_stack[$];
        a = ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5;
        b = 5'($urandom_range(6, 31));
        if (k <= 3)       put(p, pc, JAL, b, a, 1'($urandom_range(0, 1)));
        else if (k == 4)  put(p, pc, JALR, b, a, 1'($urandom_range(0, 1)));
        else if (k <= 8)  put(p, pc, JALR, a, ($urandom_range(0, 1) != 0) ? 5'd0 : b, 1'b0);
        else if (k == 9)  put(p, pc, JALR, (a == 5'd1) ? 5'd5 : 5'd1, a, 1'($urandom_range(0, 1)));
        else if (k == 10) put(p, pc, JALR, a, a, 1'($urandom_range(0, 1)));
        else if (k == 11 && $urandom_range(0, 3) == 0) put(p, pc, ADDW, 5'd1, 5'd0, 1'b0);
        else              put(p, pc, ADD, b, b, 1'b0);
        if ($urandom_range(0, 19) == 0) ci[p].ex.valid = 1'b1;
        if ($urandom_range(0, 5) == 0)  ack[p] = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        chk("reset_depth", 64'(depth_o), 64'd0);
        chk("reset_alarm", 64'(alarm_o), 64'd0);

        // call/return match
        do_call(0, 64'h8000_0000, 1'b0); step();
        chk("match_depth_push", 64'(depth_o), 64'd1);
        do_ret(0, 64'h8000_0040); step();
        chk("match_depth_pop", 64'(depth_o), 64'd0);
        do_plain(0, 64'h8000_0004); step();
        chk("match_no_violation", 64'(violation_o), 64'd0);

        // mismatch, sticky alarm, clear
        do_call(0, 64'h8000_0000, 1'b0); step();
        do_ret(0, 64'h8000_0040); step();
        do_plain(0, 64'h8000_1000); step();
        chk("mismatch_pulse", 64'(violation_o), 64'd1);
        chk("mismatch_cause", 64'(cause_o), 64'd1);
        chk("mismatch_pc", violation_pc_o, 64'h8000_1000);
        step();
        chk("mismatch_pulse_end", 64'(violation_o), 64'd0);
        chk("mismatch_alarm_held", 64'(alarm_o), 64'd1);
        clr = 1'b1; step();
        chk("clear_alarm", 64'(alarm_o), 64'd0);
        chk("clear_cause", 64'(cause_o), 64'd0);

        // same-cycle pair after a compressed call
        do_call(0, 64'h8000_0100, 1'b1); step();
        do_ret(0, 64'h8000_0180); do_plain(1, 64'h8000_0102); step();
        chk("pair_match", 64'(violation_o), 64'd0);
        do_call(0, 64'h8000_0100, 1'b1); step();
        do_ret(0, 64'h8000_0180); do_plain(1, 64'h8000_0200); step();
        chk("pair_mismatch", 64'(violation_o), 64'd1);
        chk("pair_mismatch_pc", violation_pc_o, 64'h8000_0200);
        clr = 1'b1; step();

        // overflow: DEPTH+2 calls then matching returns, then one extra
        for (int i = 0; i < DEPTH + 2; i++) begin
            do_call(0, 64'h8000_0000 + 64'(i) * 64'h100, 1'b0); step();
        end
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_depth", 64'(depth_o), 64'(DEPTH));
        for (int j = 0; j < DEPTH + 2; j++) begin
            do_ret(0, 64'h9000_0000);
            do_plain(1, 64'h8000_0000 + 64'(DEPTH + 1 - j) * 64'h100 + 64'd4);
            step();
        end
        chk("ovf_no_alarm", 64'(alarm_o), 64'd0);
        chk("ovf_lost_drained", 64'(overflow_o), 64'd0);
        do_ret(0, 64'h9000_0000); step();
        chk("ovf_underflow_cause", 64'(cause_o), 64'd2);
        clr = 1'b1; step();

        // underflow straight from reset, then reset while pending
        rst = 1'b1; step();
        do_ret(0, 64'h8000_0000); step();
        chk("underflow_pulse", 64'(violation_o), 64'd1);
        chk("underflow_cause", 64'(cause_o), 64'd2);
        do_call(0, 64'h8000_0000, 1'b0); step();
        do_ret(0, 64'h8000_0040); step();
        rst = 1'b1; step();
        chk("rst_pending_alarm", 64'(alarm_o), 64'd0);
        chk("rst_pending_cause", 64'(cause_o), 64'd0);
        chk("rst_pending_pc", violation_pc_o, 64'd0);
        do_plain(0, 64'h8000_7000); step();
        chk("rst_pending_dropped", 64'(violation_o), 64'd0);

        // software marker
        do_call(0, 64'h8000_0000, 1'b0); step();
        do_call(0, 64'h8000_0100, 1'b0); step();
        do_call(0, 64'h8000_0200, 1'b0); step();
        put(0, 64'h8000_0300, ADDW, 5'd1, 5'd0, 1'b0); step();
`ifdef CFI_MARKER_EN
        chk("marker_depth", 64'(depth_o), 64'd0);
`else
        chk("marker_depth", 64'(depth_o), 64'd3);
`endif
        do_ret(0, 64'h8000_0400); step();
        do_plain(0, 64'h8000_0204); step();
`ifdef CFI_MARKER_EN
        chk("marker_ret_cause", 64'(cause_o), 64'd2);
`else
        chk("marker_ret_cause", 64'(cause_o), 64'd0);
`endif
        clr = 1'b1; step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            clr = ($urandom_range(0, 19) == 0);
            rand_port(0);
            rand_port(1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
